rf_param_sb: RTL

//  Parametrised register file (NREGS x WIDTH): 1 write port, 3 async read ports (A, B, D).

---
 rtl/rf_param_sb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rf_param_sb.sv
// Parametrised register file (NREGS x WIDTH) with a pending-write scoreboard and sequenced clear.
// Define RF_BYPASS_EN to forward accepted writes to the read ports in the same cycle.
//
//   state    | meaning
//   ST_IDLE  | normal operation, writes/locks accepted, clr starts a clear
//   ST_CLEAR | one register (and lock bit) zeroed per cycle, requests dropped
module rf_param_sb #(
   parameter int NREGS    = 4,
   parameter int WIDTH    = 16,
   parameter int ZERO_REG = 0,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             lock_set,
   input  logic [AW-1:0]    lock_addr,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rd,
   output logic [WIDTH-1:0] opA,
   output logic [WIDTH-1:0] opB,
   output logic [WIDTH-1:0] opD,
   output logic             locked_a,
   output logic             locked_b,
   output logic             locked_d,
   output logic             busy,
   output logic             wr_drop,
   inout  wire              dvdd,
   inout  wire              dgnd
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t           r_state, w_state_nxt;
   logic [AW-1:0]    r_ptr, w_ptr_nxt;
   logic             r_busy, r_wr_drop;
   logic [NREGS-1:0] r_lock;
   logic [WIDTH-1:0] r_regs [NREGS];

   logic             w_wr_acc, w_lk_acc, w_drop_nxt;
   logic [AW-1:0]    w_rd_addr [3];
   logic [WIDTH-1:0] w_op [3];
   logic [2:0]       w_lk;

   function automatic logic f_in_range(input logic [AW-1:0] a);
      return 32'(a) < 32'(NREGS);
   endfunction

   // A "live" register physically holds state; the hardwired zero register does not.
   function automatic logic f_live(input logic [AW-1:0] a);
      return f_in_range(a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_wr_acc    = 1'b0;
      w_lk_acc    = 1'b0;
      w_drop_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_wr_acc   = wr_en && f_live(wr_addr);
            w_lk_acc   = lock_set && f_live(lock_addr);
            w_drop_nxt = (wr_en && !f_in_range(wr_addr)) ||
                         (lock_set && !f_in_range(lock_addr));
            if (clr) begin
               w_state_nxt = ST_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            w_drop_nxt = wr_en || lock_set;
            if (r_ptr == LAST) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = '0;
            end else begin
               w_ptr_nxt = r_ptr + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_busy    <= 1'b0;
         r_wr_drop <= 1'b0;
         r_lock    <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_busy    <= (w_state_nxt == ST_CLEAR);
         r_wr_drop <= w_drop_nxt;
         for (int i = 0; i < NREGS; i++) begin
            if (r_state == ST_CLEAR && r_ptr == AW'(i)) begin
               r_regs[i] <= '0;
               r_lock[i] <= 1'b0;
            end else begin
               if (w_wr_acc && wr_addr == AW'(i)) begin
                  r_regs[i] <= wr_data;
                  r_lock[i] <= 1'b0;
               end
               // A same-cycle lock on the written register marks a newer pending write.
               if (w_lk_acc && lock_addr == AW'(i)) r_lock[i] <= 1'b1;
            end
         end
      end
   end

   assign w_rd_addr[0] = ra;
   assign w_rd_addr[1] = rb;
   assign w_rd_addr[2] = rd;

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         w_op[p] = '0;
         w_lk[p] = 1'b0;
         if (f_live(w_rd_addr[p])) begin
            w_op[p] = r_regs[w_rd_addr[p]];
            w_lk[p] = r_lock[w_rd_addr[p]];
         end
`ifdef RF_BYPASS_EN
         if (w_wr_acc && wr_addr == w_rd_addr[p]) begin
            w_op[p] = wr_data;
            w_lk[p] = 1'b0;
         end
`else
`endif
      end
   end

   assign opA      = w_op[0];
   assign opB      = w_op[1];
   assign opD      = w_op[2];
   assign locked_a = w_lk[0];
   assign locked_b = w_lk[1];
   assign locked_d = w_lk[2];
   assign busy     = r_busy;
   assign wr_drop  = r_wr_drop;

endmodule
